mux2_rr_arbiter: RTL and testbench
==================================

# mux2_rr_arbiter

Two-requester round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between requester 0 and requester 1. It owns the select line, presents the granted requester's data downstream with a valid/ready handshake, and returns a per-requester acknowledge on each transfer. It sits between two producers and a single shared consumer.

## Interface
Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_BURST, 4, maximum consecutive transfers per grant. Used only when MUX2_ARB_BURST_EN is defined. Legal range is 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 has data; held until ack0
- d0  input  WIDTH  requester 0 data; stable while req0 high
- ack0  output  1  requester 0 beat transferred this cycle
- req1  input  1  requester 1 has data; held until ack1
- d1  input  WIDTH  requester 1 data; stable while req1 high
- ack1  output  1  requester 1 beat transferred this cycle
- y  output  WIDTH  shared datapath output: d1 when s=1, else d0
- y_valid  output  1  y carries a granted beat
- y_ready  input  1  consumer accepts y this cycle
- s  output  1  registered mux select (current or last grant)
- busy  output  1  high in any GRANT state

## Operation
- Datapath: WIDTH bit-slices of the existing mux2_1 cell, all driven by the registered s. No data registers.
- FSM states: IDLE, GRANT0, GRANT1. Priority pointer `prio` names the requester favoured on a tie.
- IDLE:
  - Only req0 high: go to GRANT0.
  - Only req1 high: go to GRANT1.
  - Both high: go to GRANT\<prio\>.
  - Neither high: stay in IDLE.
  - s is loaded with the chosen index on the same edge.
- GRANTn:
  - y_valid = req_n (combinational).
  - ackn = req_n & y_ready (combinational). The other ack is 0.
  - Transfer = y_valid & y_ready.
- On a transfer in GRANTn:
  - prio becomes the other index.
  - Re-arbitrate on the same edge using the current req levels and the new prio, with the same rules as IDLE.
  - The next state may be GRANT0, GRANT1 or IDLE. There is no bubble cycle.
- Withdrawal: if req_n is low in GRANTn, no transfer happens. The FSM goes to IDLE on the next edge and prio is unchanged.
- Stall: while y_ready is low, state, s and prio hold and y_valid stays high.
- s is never changed except on an edge where the FSM enters a GRANT state.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, s=0, prio=0, burst count=0.
  - y_valid=0, ack0=0, ack1=0, busy=0.
  - y=d0 combinationally, because s=0.
- Reset mid-transfer drops to IDLE on the edge. No ack is issued in the reset cycle (rst gates ack0/ack1/y_valid low).
- Latency: a req seen in IDLE at cycle N gives y_valid=1 in cycle N+1. The earliest ack is in cycle N+1.
- Throughput: one beat per cycle while y_ready is high and a request is pending.
- Both requesting continuously with y_ready=1 (no burst feature): grants alternate 0,1,0,1,... every cycle, starting with 0 after reset.
- Simultaneous requests arriving in IDLE are resolved by prio only.
- A new req from the non-granted side during a stall waits. It does not preempt.

## Configuration
- MUX2_ARB_BURST_EN defined:
  - A 4-bit burst counter counts consecutive transfers of the current grant.
  - On a transfer, the grant stays with the same requester, and prio is unchanged, if req_n is still high and count+1 < MAX_BURST. If the other requester is idle, the grant also stays.
  - Otherwise the grant switches as in Operation and the count clears.
  - The count clears on entry to IDLE and on reset.
- MUX2_ARB_BURST_EN undefined: strict per-beat round-robin. There is no counter and MAX_BURST is ignored.

## Test plan
- Reset, then req0=1, d0=8'hA5, req1=0, y_ready=1:
  - Cycle 1: y_valid=1, y=8'hA5, s=0, ack0=1.
  - busy stays high while req0 is held.
- Both req high from IDLE after reset, d0=8'h11, d1=8'h22, y_ready=1, no burst:
  - y sequence is 11,22,11,22.
  - ack0 and ack1 alternate each cycle.
- Stall: grant 1 with y_ready=0 for 3 cycles while req0=1:
  - s=1, y_valid=1, ack1=0 hold for 3 cycles.
  - y_ready=1 gives ack1=1, then a switch to GRANT0 on the next edge.
- Withdrawal: in GRANT0, drop req0 with y_ready=0:
  - y_valid=0 the same cycle, IDLE on the next edge, prio unchanged.
- Assert rst during GRANT1 with y_ready=1:
  - ack1=0 in that cycle.
  - Next cycle: state IDLE, s=0, busy=0, y_valid=0.
- MUX2_ARB_BURST_EN, MAX_BURST=3, both req held, y_ready=1:
  - Grant pattern is 0,0,0,1,1,1,0,...
  - With only req0 high, grant 0 continues past 3 beats.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Round-robin arbiter for two requesters that share one WIDTH-bit 2:1 mux
// datapath. The arbiter owns the registered select line s, presents the
// granted requester's data downstream with a valid/ready handshake, and
// returns a per-requester acknowledge on each accepted beat. No data is
// registered; y is always the mux of d0/d1 under s.
//
// Parameters:
//   WIDTH      data width of d0, d1 and y
//   MAX_BURST  consecutive beats per grant (1..15), burst build only
//
// Ports:
//   clk      single clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   req0/d0  requester 0 request and data, held until ack0
//   ack0     requester 0 beat transferred this cycle
//   req1/d1  requester 1 request and data, held until ack1
//   ack1     requester 1 beat transferred this cycle
//   y        shared output: d1 when s=1, else d0
//   y_valid  y carries a granted beat
//   y_ready  consumer accepts y this cycle
//   s        registered mux select (current or last grant)
//   busy     high in any GRANT state
//
// Configuration macro:
//   MUX2_ARB_BURST_EN  when defined, a grant is kept for up to MAX_BURST
//                      consecutive beats (or indefinitely while the other
//                      requester is idle). When undefined, arbitration is
//                      strict per-beat round-robin and MAX_BURST is unused.
// -----------------------------------------------------------------------------

// Single-bit 2:1 mux cell: y = sel ? b : a.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack1,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             s,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   s_next;
  logic   prio, prio_next;

  logic   grant_active;
  logic   cur_idx;
  logic   cur_req;
  logic   other_req;

`ifdef MUX2_ARB_BURST_EN
  localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

  logic [3:0] burst_cnt, burst_cnt_next;
  logic       burst_keep;
`endif

  // Tie-break helper: both requesting -> favoured index p, otherwise
  // whichever one is requesting (callers only use the result when at
  // least one request is present).
  function automatic logic arb_pick(input logic r0, input logic r1, input logic p);
    if (r0 && r1) begin
      return p;
    end
    return r1;
  endfunction

  // Datapath: one mux2_1 cell per bit, all steered by the registered select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux2_1 u_mux (
      .a   (d0[i]),
      .b   (d1[i]),
      .sel (s),
      .y   (y[i])
    );
  end

  // Request level of the currently granted side; zero when idle.
  assign grant_active = (state == GRANT0) || (state == GRANT1);
  assign cur_idx      = (state == GRANT1);
  assign cur_req      = grant_active && (cur_idx ? req1 : req0);
  assign other_req    = cur_idx ? req0 : req1;

  // Handshake outputs are combinational off the grant and are forced low
  // during reset so no beat is acknowledged in the reset cycle.
  assign y_valid = cur_req && !rst;
  assign ack0    = (state == GRANT0) && req0 && y_ready && !rst;
  assign ack1    = (state == GRANT1) && req1 && y_ready && !rst;
  assign busy    = grant_active;

`ifdef MUX2_ARB_BURST_EN
  // The current requester keeps the grant while it is under its burst
  // allowance, or for as long as the other side has nothing to send.
  assign burst_keep = (({1'b0, burst_cnt} + 5'd1) < BURST_LIMIT) || !other_req;
`endif

  // Next-state logic. Re-arbitration after a transfer happens on the same
  // edge as the transfer, so back-to-back beats have no bubble. A withdrawn
  // request returns to IDLE without touching prio or s.
  always_comb begin
    state_next = state;
    s_next     = s;
    prio_next  = prio;
`ifdef MUX2_ARB_BURST_EN
    burst_cnt_next = burst_cnt;
`endif

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          s_next     = arb_pick(req0, req1, prio);
          state_next = arb_pick(req0, req1, prio) ? GRANT1 : GRANT0;
        end
      end

      GRANT0, GRANT1: begin
        if (!cur_req) begin
          state_next = IDLE;
`ifdef MUX2_ARB_BURST_EN
          burst_cnt_next = 4'd0;
`endif
        end else if (y_ready) begin
`ifdef MUX2_ARB_BURST_EN
          if (burst_keep) begin
            // Saturate so a long uncontended run cannot wrap the count.
            burst_cnt_next = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
          end else begin
            burst_cnt_next = 4'd0;
            prio_next      = !cur_idx;
            s_next         = arb_pick(req0, req1, !cur_idx);
            state_next     = arb_pick(req0, req1, !cur_idx) ? GRANT1 : GRANT0;
          end
`else
          prio_next  = !cur_idx;
          s_next     = arb_pick(req0, req1, !cur_idx);
          state_next = arb_pick(req0, req1, !cur_idx) ? GRANT1 : GRANT0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
`ifdef MUX2_ARB_BURST_EN
        burst_cnt_next = 4'd0;
`endif
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      prio  <= 1'b0;
`ifdef MUX2_ARB_BURST_EN
      burst_cnt <= 4'd0;
`endif
    end else begin
      state <= state_next;
      s     <= s_next;
      prio  <= prio_next;
`ifdef MUX2_ARB_BURST_EN
      burst_cnt <= burst_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//
// Self-checking bench for mux2_rr_arbiter. A table of per-cycle vectors
// walks the arbiter through reset, single-requester grants, alternation,
// stall, withdrawal and reset mid-grant; hand-written sequences cover
// continuous alternation (or burst grants when MUX2_ARB_BURST_EN is set).
// -----------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;
`ifdef MUX2_ARB_BURST_EN
  localparam int MAX_BURST = 3;
`else
  localparam int MAX_BURST = 4;
`endif

  logic             clk;
  logic             rst;
  logic             req0;
  logic [WIDTH-1:0] d0;
  logic             ack0;
  logic             req1;
  logic [WIDTH-1:0] d1;
  logic             ack1;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             s;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux2_rr_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .d0      (d0),
    .ack0    (ack0),
    .req1    (req1),
    .d1      (d1),
    .ack1    (ack1),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .s       (s),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       req0;
    logic       req1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       y_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       ack0;
    logic       ack1;
    logic       s;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    req0    = v.req0;
    req1    = v.req1;
    d0      = v.d0;
    d1      = v.d1;
    y_ready = v.y_ready;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    checkOutput("y",       idx, y,              v.y);
    checkOutput("y_valid", idx, {7'd0, y_valid}, {7'd0, v.y_valid});
    checkOutput("ack0",    idx, {7'd0, ack0},    {7'd0, v.ack0});
    checkOutput("ack1",    idx, {7'd0, ack1},    {7'd0, v.ack1});
    checkOutput("s",       idx, {7'd0, s},       {7'd0, v.s});
    checkOutput("busy",    idx, {7'd0, busy},    {7'd0, v.busy});
  endtask

  initial begin
    int waited;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; y_ready = 1'b1;
    repeat (2) @(posedge clk);

`ifndef MUX2_ARB_BURST_EN
    // Fields: rst req0 req1 d0 d1 y_ready | y y_valid ack0 ack1 s busy
    vecs.push_back('{1, 0, 0, 8'hA5, 8'h5A, 1, 8'hA5, 0, 0, 0, 0, 0}); //  0 reset
    vecs.push_back('{0, 1, 0, 8'hA5, 8'h5A, 1, 8'hA5, 0, 0, 0, 0, 0}); //  1 IDLE sees req0
    vecs.push_back('{0, 1, 0, 8'hA5, 8'h5A, 1, 8'hA5, 1, 1, 0, 0, 1}); //  2 GRANT0 beat
    vecs.push_back('{0, 1, 0, 8'hA5, 8'h5A, 1, 8'hA5, 1, 1, 0, 0, 1}); //  3 GRANT0 again
    vecs.push_back('{0, 0, 0, 8'hA5, 8'h5A, 1, 8'hA5, 0, 0, 0, 0, 1}); //  4 withdraw
    vecs.push_back('{1, 0, 0, 8'h11, 8'h22, 1, 8'h11, 0, 0, 0, 0, 0}); //  5 reset
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h11, 0, 0, 0, 0, 0}); //  6 IDLE both
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h11, 1, 1, 0, 0, 1}); //  7 grant 0
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h22, 1, 0, 1, 1, 1}); //  8 grant 1
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h11, 1, 1, 0, 0, 1}); //  9 grant 0
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h22, 1, 0, 1, 1, 1}); // 10 grant 1
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h11, 1, 1, 0, 0, 1}); // 11 grant 0
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 0, 8'h22, 1, 0, 0, 1, 1}); // 12 stall GRANT1
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 0, 8'h22, 1, 0, 0, 1, 1}); // 13 stall
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 0, 8'h22, 1, 0, 0, 1, 1}); // 14 stall
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h22, 1, 0, 1, 1, 1}); // 15 release
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 0, 8'h11, 1, 0, 0, 0, 1}); // 16 GRANT0 stalled
    vecs.push_back('{0, 0, 1, 8'h11, 8'h22, 0, 8'h11, 0, 0, 0, 0, 1}); // 17 req0 withdrawn
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 0, 8'h11, 0, 0, 0, 0, 0}); // 18 IDLE, prio still 0
    vecs.push_back('{0, 1, 1, 8'h11, 8'h22, 1, 8'h11, 1, 1, 0, 0, 1}); // 19 grant 0
    vecs.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 8'h22, 0, 0, 0, 1, 1}); // 20 reset in GRANT1
    vecs.push_back('{0, 0, 0, 8'h11, 8'h22, 1, 8'h11, 0, 0, 0, 0, 0}); // 21 after reset
    vecs.push_back('{0, 0, 1, 8'h11, 8'h22, 1, 8'h11, 0, 0, 0, 0, 0}); // 22 IDLE sees req1
    vecs.push_back('{0, 0, 1, 8'h11, 8'h22, 1, 8'h22, 1, 0, 1, 1, 1}); // 23 GRANT1 beat
    vecs.push_back('{0, 0, 0, 8'h11, 8'h22, 1, 8'h22, 0, 0, 0, 1, 1}); // 24 req1 withdrawn
    vecs.push_back('{0, 0, 0, 8'h11, 8'h22, 1, 8'h22, 0, 0, 0, 1, 0}); // 25 IDLE, s held

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      #3;
      checkVector(vecs[i], i);
    end

    // Continuous requests from reset: grants alternate starting with 0.
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22; y_ready = 1'b1;
    #3;
    checkOutput("idle_valid", 100, {7'd0, y_valid}, 8'd0);
    waited = 0;
    while (waited < 4) begin
      @(posedge clk); #4;
      waited++;
      if (y_valid) break;
    end
    checkOutput("grant_latency", 101, 8'(waited), 8'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("alt_ack0", 110 + k, {7'd0, ack0}, {7'd0, (k % 2) == 0});
      checkOutput("alt_ack1", 110 + k, {7'd0, ack1}, {7'd0, (k % 2) == 1});
      checkOutput("alt_y",    110 + k, y, ((k % 2) == 0) ? 8'h11 : 8'h22);
      checkOutput("alt_s",    110 + k, {7'd0, s}, {7'd0, (k % 2) == 1});
      @(posedge clk); #4;
    end
`else
    begin
      int pat[7] = '{0, 0, 0, 1, 1, 1, 0};
      int exp_g;

      @(posedge clk); #1;
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22; y_ready = 1'b1;
      #3;
      checkOutput("idle_valid", 200, {7'd0, y_valid}, 8'd0);
      // Both held for 7 beats, then only req0 keeps asking.
      for (int i = 0; i < 13; i++) begin
        @(posedge clk); #1;
        req1 = (i < 7);
        #3;
        exp_g = (i < 7) ? pat[i] : 0;
        checkOutput("burst_ack0", 210 + i, {7'd0, ack0}, {7'd0, exp_g == 0});
        checkOutput("burst_ack1", 210 + i, {7'd0, ack1}, {7'd0, exp_g == 1});
        checkOutput("burst_s",    210 + i, {7'd0, s},    8'(exp_g));
        checkOutput("burst_y",    210 + i, y, (exp_g == 0) ? 8'h11 : 8'h22);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
